// File: rtl/game_status_tracker.sv
// rtl/game_status_tracker.sv - round end, score, pellet and lives tracking for the play state
module game_status_tracker #(
  parameter int NUM_LIVES     = 3,
  parameter int TOTAL_PELLETS = 240,
  parameter int DEATH_FRAMES  = 120,
  parameter int SCORE_W       = 16,
  parameter int PELLET_PTS    = 10,
  parameter int POWER_PTS     = 50,
  parameter int GHOST_PTS     = 200
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_tick,
  input  logic               playon,
  input  logic               pellet_eaten,
  input  logic               power_eaten,
  input  logic               ghost_eaten,
  input  logic               ghost_hit,
  output logic               isGameOver,
  output logic               win,
  output logic [3:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic               freeze,
  output logic               respawn
);

  // Pellet counter is at least 2 bits so a double decrement never truncates.
  localparam int PW_RAW = $clog2(TOTAL_PELLETS + 1);
  localparam int PW     = (PW_RAW < 2) ? 2 : PW_RAW;
  localparam int DW_RAW = $clog2(DEATH_FRAMES);
  localparam int DW     = (DW_RAW < 1) ? 1 : DW_RAW;
  // Headroom above the score so a multi-award cycle can be detected as overflow.
  localparam int SUM_W  = SCORE_W + 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAY,
    S_DYING,
    S_RESPAWN,
    S_OVER
  } state_t;

  state_t               state_q, state_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [PW-1:0]        pellets_q, pellets_d;
  logic [3:0]           lives_q, lives_d;
  logic                 win_q, win_d;
  logic [DW-1:0]        death_cnt_q, death_cnt_d;

  logic [SUM_W-1:0]     score_sum;
  logic [PW-1:0]        pellet_dec;
  logic [PW-1:0]        pellets_left;

  // Next-state, scoring and counter updates for the round.
  always_comb begin
    state_d     = state_q;
    score_d     = score_q;
    pellets_d   = pellets_q;
    lives_d     = lives_q;
    win_d       = win_q;
    death_cnt_d = death_cnt_q;

    score_sum    = SUM_W'(score_q)
                 + (pellet_eaten ? SUM_W'(PELLET_PTS) : '0)
                 + (power_eaten  ? SUM_W'(POWER_PTS)  : '0)
                 + (ghost_eaten  ? SUM_W'(GHOST_PTS)  : '0);
    pellet_dec   = PW'({1'b0, pellet_eaten}) + PW'({1'b0, power_eaten});
    pellets_left = (pellets_q > pellet_dec) ? (pellets_q - pellet_dec) : '0;

    case (state_q)
      S_IDLE: begin
        if (playon) begin
          lives_d   = 4'(NUM_LIVES);
          pellets_d = PW'(TOTAL_PELLETS);
          score_d   = '0;
          win_d     = 1'b0;
          state_d   = S_PLAY;
        end
      end
      S_PLAY: begin
        if (!playon) begin
          state_d = S_IDLE;
        end else begin
          if (|score_sum[SUM_W-1:SCORE_W]) begin
            score_d = '1;
          end else begin
            score_d = score_sum[SCORE_W-1:0];
          end
          pellets_d = pellets_left;
          // Clearing the maze wins even if a ghost touched Pac-Man this cycle.
          if (pellets_left == '0) begin
            win_d   = 1'b1;
            state_d = S_OVER;
          end else if (ghost_hit && !ghost_eaten) begin
            lives_d     = (lives_q != 4'd0) ? (lives_q - 4'd1) : 4'd0;
            death_cnt_d = '0;
            state_d     = S_DYING;
          end
        end
      end
      S_DYING: begin
        if (!playon) begin
          state_d = S_IDLE;
        end else if (frame_tick) begin
          if (death_cnt_q == DW'(DEATH_FRAMES - 1)) begin
            if (lives_q == 4'd0) begin
              win_d   = 1'b0;
              state_d = S_OVER;
            end else begin
              state_d = S_RESPAWN;
            end
          end else begin
            death_cnt_d = death_cnt_q + DW'(1);
          end
        end
      end
      S_RESPAWN: begin
        state_d = playon ? S_PLAY : S_IDLE;
      end
      S_OVER: begin
        if (!playon) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      score_q     <= '0;
      pellets_q   <= PW'(TOTAL_PELLETS);
      lives_q     <= 4'(NUM_LIVES);
      win_q       <= 1'b0;
      death_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      pellets_q   <= pellets_d;
      lives_q     <= lives_d;
      win_q       <= win_d;
      death_cnt_q <= death_cnt_d;
    end
  end

  assign isGameOver = (state_q == S_OVER);
  assign freeze     = (state_q != S_PLAY);
  assign respawn    = (state_q == S_RESPAWN);
  assign win        = win_q;
  assign lives      = lives_q;
  assign score      = score_q;

endmodule

// File: tb/tb_game_status_tracker.sv
// tb/tb_game_status_tracker.sv - directed bench with behavioural round model for game_status_tracker
module tb_game_status_tracker;

  // Instance 0: NUM_LIVES=3, TOTAL_PELLETS=4, DEATH_FRAMES=3, SCORE_W=8
  // Instance 1: NUM_LIVES=1, TOTAL_PELLETS=1, DEATH_FRAMES=3, SCORE_W=16
  localparam int PH_IDLE  = 0;
  localparam int PH_PLAY  = 1;
  localparam int PH_DEATH = 2;
  localparam int PH_RESP  = 3;
  localparam int PH_OVER  = 4;

  logic        Clk;
  logic        rst;
  logic [1:0]  po, ft, pe, pw, ge, gh;
  logic [1:0]  go, wn, fz, rs;
  logic [3:0]  lives0, lives1;
  logic [7:0]  score0;
  logic [15:0] score1;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  int m_ph[2];
  int m_score[2];
  int m_pel[2];
  int m_lives[2];
  int m_win[2];
  int m_frames[2];

  game_status_tracker #(
    .NUM_LIVES(3), .TOTAL_PELLETS(4), .DEATH_FRAMES(3), .SCORE_W(8)
  ) dut0 (
    .Clk(Clk), .Reset(rst), .frame_tick(ft[0]), .playon(po[0]),
    .pellet_eaten(pe[0]), .power_eaten(pw[0]), .ghost_eaten(ge[0]), .ghost_hit(gh[0]),
    .isGameOver(go[0]), .win(wn[0]), .lives(lives0), .score(score0),
    .freeze(fz[0]), .respawn(rs[0])
  );

  game_status_tracker #(
    .NUM_LIVES(1), .TOTAL_PELLETS(1), .DEATH_FRAMES(3), .SCORE_W(16)
  ) dut1 (
    .Clk(Clk), .Reset(rst), .frame_tick(ft[1]), .playon(po[1]),
    .pellet_eaten(pe[1]), .power_eaten(pw[1]), .ghost_eaten(ge[1]), .ghost_hit(gh[1]),
    .isGameOver(go[1]), .win(wn[1]), .lives(lives1), .score(score1),
    .freeze(fz[1]), .respawn(rs[1])
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic cmp(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Round rules applied to the inputs seen at one clock edge.
  task automatic model_step(input int i);
    int nl, tp, df, smax, add, left;
    nl   = (i == 0) ? 3 : 1;
    tp   = (i == 0) ? 4 : 1;
    df   = 3;
    smax = (i == 0) ? 255 : 65535;
    if (rst) begin
      m_ph[i] = PH_IDLE; m_score[i] = 0; m_pel[i] = tp;
      m_lives[i] = nl; m_win[i] = 0; m_frames[i] = 0;
      return;
    end
    case (m_ph[i])
      PH_IDLE: if (po[i]) begin
        m_lives[i] = nl; m_pel[i] = tp; m_score[i] = 0; m_win[i] = 0;
        m_ph[i] = PH_PLAY;
      end
      PH_PLAY: if (!po[i]) m_ph[i] = PH_IDLE;
      else begin
        add = 10 * int'(pe[i]) + 50 * int'(pw[i]) + 200 * int'(ge[i]);
        m_score[i] = (m_score[i] + add > smax) ? smax : m_score[i] + add;
        left = m_pel[i] - int'(pe[i]) - int'(pw[i]);
        m_pel[i] = (left < 0) ? 0 : left;
        if (m_pel[i] == 0) begin
          m_win[i] = 1; m_ph[i] = PH_OVER;
        end else if (gh[i] && !ge[i]) begin
          m_lives[i] = (m_lives[i] > 0) ? m_lives[i] - 1 : 0;
          m_frames[i] = 0; m_ph[i] = PH_DEATH;
        end
      end
      PH_DEATH: if (!po[i]) m_ph[i] = PH_IDLE;
      else if (ft[i]) begin
        m_frames[i]++;
        if (m_frames[i] == df) m_ph[i] = (m_lives[i] == 0) ? PH_OVER : PH_RESP;
      end
      PH_RESP: m_ph[i] = po[i] ? PH_PLAY : PH_IDLE;
      default: if (!po[i]) m_ph[i] = PH_IDLE;
    endcase
  endtask

  task automatic step();
    @(posedge Clk);
    model_step(0);
    model_step(1);
    @(negedge Clk);
    ft = '0; pe = '0; pw = '0; ge = '0; gh = '0;
  endtask

  // Every-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge Clk);
      if (chk_en) begin
        for (int i = 0; i < 2; i++) begin
          cmp($sformatf("d%0d_isGameOver", i), int'(go[i]), int'(m_ph[i] == PH_OVER));
          cmp($sformatf("d%0d_win", i), int'(wn[i]), m_win[i]);
          cmp($sformatf("d%0d_lives", i), (i == 0) ? int'(lives0) : int'(lives1), m_lives[i]);
          cmp($sformatf("d%0d_score", i), (i == 0) ? int'(score0) : int'(score1), m_score[i]);
          cmp($sformatf("d%0d_freeze", i), int'(fz[i]), int'(m_ph[i] != PH_PLAY));
          cmp($sformatf("d%0d_respawn", i), int'(rs[i]), int'(m_ph[i] == PH_RESP));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    po = '0; ft = '0; pe = '0; pw = '0; ge = '0; gh = '0;
    step();
    step();
    rst = 1'b0;
    chk_en = 1'b1;
    cmp("rst_lives0", int'(lives0), 3);
    cmp("rst_lives1", int'(lives1), 1);
    cmp("rst_score0", int'(score0), 0);
    cmp("rst_freeze0", int'(fz[0]), 1);
    cmp("rst_gameover0", int'(go[0]), 0);

    // Last life lost: OVER with win=0, held while playon stays high.
    po[1] = 1'b1; step();
    gh[1] = 1'b1; step();
    cmp("die_lives1", int'(lives1), 0);
    for (int k = 0; k < 3; k++) begin
      ft[1] = 1'b1; step();
    end
    cmp("lose_gameover", int'(go[1]), 1);
    cmp("lose_win", int'(wn[1]), 0);
    repeat (50) step();
    cmp("lose_hold_gameover", int'(go[1]), 1);
    po[1] = 1'b0; step();
    cmp("lose_idle_gameover", int'(go[1]), 0);

    // Last pellet and a ghost hit together: win, no life lost.
    po[1] = 1'b1; step();
    pe[1] = 1'b1; gh[1] = 1'b1; step();
    cmp("tie_win", int'(wn[1]), 1);
    cmp("tie_gameover", int'(go[1]), 1);
    cmp("tie_lives", int'(lives1), 1);
    cmp("tie_score", int'(score1), 10);
    po[1] = 1'b0; step();

    // Clear the 4-pellet maze: 3 pellets + 1 power pellet.
    po[0] = 1'b1; step();
    for (int k = 0; k < 3; k++) begin
      pe[0] = 1'b1; step();
    end
    pw[0] = 1'b1; step();
    cmp("clear_score", int'(score0), 80);
    cmp("clear_win", int'(wn[0]), 1);
    cmp("clear_gameover", int'(go[0]), 1);
    po[0] = 1'b0; step();
    cmp("clear_idle_gameover", int'(go[0]), 0);
    cmp("clear_idle_score", int'(score0), 80);

    // External abort: pellet on the playon-low cycle is not scored.
    po[0] = 1'b1; step();
    pe[0] = 1'b1; step();
    pe[0] = 1'b1; po[0] = 1'b0; step();
    cmp("abort_score", int'(score0), 10);
    cmp("abort_freeze", int'(fz[0]), 1);

    // Death with lives left, then a one-cycle respawn.
    po[0] = 1'b1; step();
    gh[0] = 1'b1; step();
    cmp("die_lives0", int'(lives0), 2);
    cmp("die_freeze0", int'(fz[0]), 1);
    ft[0] = 1'b1; step();
    step();
    ft[0] = 1'b1; step();
    ft[0] = 1'b1; step();
    cmp("respawn_pulse", int'(rs[0]), 1);
    step();
    cmp("respawn_done", int'(rs[0]), 0);
    cmp("respawn_freeze", int'(fz[0]), 0);

    // Simultaneous awards, ghost eaten cancels the hit, 8-bit saturation.
    pe[0] = 1'b1; pw[0] = 1'b1; step();
    cmp("double_score", int'(score0), 60);
    gh[0] = 1'b1; ge[0] = 1'b1; step();
    cmp("sat_score", int'(score0), 255);
    cmp("hit_ignored_freeze", int'(fz[0]), 0);
    cmp("hit_ignored_lives", int'(lives0), 2);
    ge[0] = 1'b1; step();
    cmp("sat_hold", int'(score0), 255);
    ft[0] = 1'b1; step();
    gh[0] = 1'b1; step();
    ft[0] = 1'b1; step();

    // Reset while dying.
    rst = 1'b1; step();
    rst = 1'b0;
    cmp("rst_dying_score", int'(score0), 0);
    cmp("rst_dying_lives", int'(lives0), 3);
    cmp("rst_dying_freeze", int'(fz[0]), 1);
    po = '0;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/game_status_tracker.md
Name: game_status_tracker

Overview:
- Decides when a round of play ends.
- Counts score, remaining pellets and lives while the top-level background state machine is in its play state (playon high).
- Asserts isGameOver back to that state machine when the round is won or lost.
- Drives freeze and respawn to the Pac-Man/ghost motion logic.

Parameters:
NUM_LIVES, 3, lives loaded at the start of every round (1..15)
TOTAL_PELLETS, 240, pellets plus power pellets in the maze
DEATH_FRAMES, 120, frame_tick count spent in the death animation
SCORE_W, 16, score width
PELLET_PTS, 10, points per pellet
POWER_PTS, 50, points per power pellet
GHOST_PTS, 200, points per ghost eaten

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
frame_tick  in  1  one-Clk pulse per video frame
playon  in  1  high while the top-level state machine is in play
pellet_eaten  in  1  one-Clk pulse, normal pellet consumed
power_eaten  in  1  one-Clk pulse, power pellet consumed
ghost_eaten  in  1  one-Clk pulse, Pac-Man ate a frightened ghost
ghost_hit  in  1  one-Clk pulse, Pac-Man touched a live ghost
isGameOver  out  1  round ended, level-held
win  out  1  round ended with all pellets eaten
lives  out  4  lives remaining
score  out  SCORE_W  current or last-round score
freeze  out  1  hold all sprite motion
respawn  out  1  one-Clk pulse, reset sprites to start positions

Behaviour:
- Reset values: state IDLE, isGameOver 0, win 0, lives NUM_LIVES, score 0, pellet counter TOTAL_PELLETS, freeze 1, respawn 0, death counter 0.
- All outputs are registered or decoded from the registered state. An event sampled in cycle n is visible in cycle n+1.
- freeze = 1 in every state except PLAY.
- isGameOver = 1 only in OVER.

States:
- IDLE:
  - Score and win hold their last-round values, so the game-over screen can show them.
  - On playon = 1: load lives = NUM_LIVES, pellets = TOTAL_PELLETS, score = 0, win = 0, then go to PLAY.
- PLAY: evaluate in this priority order each cycle.
  1. Scoring:
     - Add PELLET_PTS if pellet_eaten, POWER_PTS if power_eaten, GHOST_PTS if ghost_eaten.
     - Pulses on the same cycle add together.
     - Score saturates at 2^SCORE_W-1 and never wraps.
  2. Pellet counter:
     - Decrement by pellet_eaten + power_eaten (0, 1 or 2).
     - Saturates at 0.
     - If the decremented value is 0: go to OVER with win = 1. This takes priority over a ghost_hit in the same cycle.
  3. Death:
     - ghost_hit with ghost_eaten low: go to DYING, lives decrement by 1 (saturating at 0), death counter clears.
     - ghost_hit with ghost_eaten high on the same cycle: the hit is ignored.
- DYING:
  - Death counter increments on each frame_tick.
  - When the counter reaches DEATH_FRAMES-1 and a tick arrives: go to OVER (win = 0) if lives = 0, otherwise go to RESPAWN.
  - All pellet and ghost inputs are ignored.
- RESPAWN:
  - Lasts exactly one Clk; respawn = 1 during it.
  - Next state is PLAY.
- OVER:
  - isGameOver held high while playon = 1.
  - When playon = 0: go to IDLE.
  - Inputs are ignored.
- Any of PLAY, DYING or RESPAWN seeing playon = 0 goes to IDLE next cycle, with no scoring on that cycle (external abort).
- Reset mid-round returns to the reset values above on the next edge, regardless of state.
- frame_tick outside DYING has no effect.

Test Plan:
- Params TOTAL_PELLETS=4, NUM_LIVES=3. Raise playon, pulse pellet_eaten 3 times, then power_eaten once → score 80, pellet counter 0, win=1, isGameOver=1 one cycle after the 4th pulse. Drop playon → IDLE next cycle, score still 80.
- DEATH_FRAMES=3, NUM_LIVES=3. In PLAY pulse ghost_hit → lives 2, freeze=1. Give 3 frame_ticks → respawn pulse for exactly 1 cycle, then PLAY with freeze=0.
- NUM_LIVES=1. One ghost_hit, then 3 frame_ticks → OVER with win=0, isGameOver=1, lives 0. isGameOver stays high for 50 cycles while playon holds.
- ghost_hit and ghost_eaten in the same cycle → no death, score +200, state stays PLAY. pellet_eaten and power_eaten in the same cycle → +60, pellet counter −2.
- TOTAL_PELLETS=1. pellet_eaten and ghost_hit in the same cycle → OVER with win=1, lives unchanged.
- SCORE_W=8. Drive 2 ghost_eaten pulses (400) → score saturates at 255. Assert Reset in DYING → next cycle IDLE, score 0, lives NUM_LIVES, freeze=1.
